// File: rtl/ifm_bram_ctrl_if.sv
// Bundle of the IFM BRAM controller's job, upstream-beat, BRAM and IFM stream signals.
// The slave modport is the controller's view; the master modport is the view of
// whatever drives jobs and beats and hosts the BRAM.
// IFM_BRAM_CTRL_PERF_EN adds the perf_cycles counter output.
interface ifm_bram_ctrl_if #(
  parameter int unsigned LEN_W = 32
);
  logic             start;
  logic [LEN_W-1:0] load_len;
  logic [LEN_W-1:0] read_len;
  logic             in_valid;
  logic [127:0]     in_data;
  logic             in_ready;
  logic             bram_wr_en;
  logic [31:0]      bram_wr_addr;
  logic [127:0]     bram_data_in;
  logic [31:0]      bram_rd_addr;
  logic [31:0]      bram_data_out;
  logic             ifm_valid;
  logic [31:0]      ifm_data;
  logic             busy;
  logic             done;
`ifdef IFM_BRAM_CTRL_PERF_EN
  logic [31:0]      perf_cycles;
`endif

  modport master (
    output start, load_len, read_len, in_valid, in_data, bram_data_out,
    input  in_ready, bram_wr_en, bram_wr_addr, bram_data_in, bram_rd_addr,
    input  ifm_valid, ifm_data, busy, done
`ifdef IFM_BRAM_CTRL_PERF_EN
    , input perf_cycles
`endif
  );

  modport slave (
    input  start, load_len, read_len, in_valid, in_data, bram_data_out,
    output in_ready, bram_wr_en, bram_wr_addr, bram_data_in, bram_rd_addr,
    output ifm_valid, ifm_data, busy, done
`ifdef IFM_BRAM_CTRL_PERF_EN
    , output perf_cycles
`endif
  );
endinterface

// File: rtl/ifm_bram_ctrl.sv
// IFM BRAM controller: loads 128-bit beats into the IFM BRAM, then streams words back
// out one per cycle. Job sequence: IDLE -> LOAD -> FLUSH -> READ -> DRAIN -> DONE.
// Optional macro IFM_BRAM_CTRL_PERF_EN adds perf_cycles (cycles from leaving IDLE
// to entering DONE, held until the next start).
module ifm_bram_ctrl #(
  parameter int unsigned DEPTH = 100352,
  parameter int unsigned LEN_W = 32
) (
  input logic            clk,
  input logic            rst,
  ifm_bram_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StRead,
    StDrain,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] load_len_q, load_len_d;
  logic [LEN_W-1:0] read_len_q, read_len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             wr_en_q;
  logic [31:0]      wr_addr_q;
  logic [127:0]     wr_data_q;
  logic             ifm_valid_q;
  logic             beat_acc;

  assign beat_acc = bus.in_valid && (state_q == StLoad);

  // Next-state and counter logic; lengths are latched once so mid-job input changes are inert.
  always_comb begin
    state_d    = state_q;
    load_len_d = load_len_q;
    read_len_d = read_len_q;
    beat_cnt_d = beat_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          load_len_d = bus.load_len;
          read_len_d = bus.read_len;
          beat_cnt_d = '0;
          rd_cnt_d   = '0;
          // Fewer than one full beat means nothing to load.
          state_d    = ((bus.load_len >> 2) == '0) ? StFlush : StLoad;
        end
      end
      StLoad: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q + 1'b1 == (load_len_q >> 2)) state_d = StFlush;
        end
      end
      StFlush: begin
        // Gives the final registered write a cycle to commit before the first read.
        state_d = (read_len_q == '0) ? StDone : StRead;
      end
      StRead: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q + 1'b1 == read_len_q) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state and job counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      load_len_q <= '0;
      read_len_q <= '0;
      beat_cnt_q <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_len_q <= load_len_d;
      read_len_q <= read_len_d;
      beat_cnt_q <= beat_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // Registered BRAM write port: one write the cycle after each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= beat_acc;
      if (beat_acc) begin
        wr_addr_q <= 32'(beat_cnt_q << 2);
        wr_data_q <= bus.in_data;
      end
    end
  end

  // Read data returns one cycle after each issue, so valid is the issue flag delayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifm_valid_q <= 1'b0;
    end else begin
      ifm_valid_q <= (state_q == StRead);
    end
  end

  // Jobs longer than the attached BRAM are a caller error.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StIdle && bus.start) begin
      assert (bus.load_len <= LEN_W'(DEPTH) && bus.read_len <= LEN_W'(DEPTH));
    end
  end

  assign bus.in_ready     = (state_q == StLoad);
  assign bus.bram_wr_en   = wr_en_q;
  assign bus.bram_wr_addr = wr_addr_q;
  assign bus.bram_data_in = wr_data_q;
  assign bus.bram_rd_addr = (state_q == StRead) ? 32'(rd_cnt_q << 2) : '0;
  assign bus.ifm_valid    = ifm_valid_q;
  // Masked so the stream reads zero outside valid cycles and during reset.
  assign bus.ifm_data     = ifm_valid_q ? bus.bram_data_out : '0;
  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = (state_q == StDone);

`ifdef IFM_BRAM_CTRL_PERF_EN
  logic [31:0] perf_q;

  // Counts the LOAD..DRAIN cycles of a job; cleared on start, held after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (state_q == StIdle && bus.start) begin
      perf_q <= '0;
    end else if (state_q inside {StLoad, StFlush, StRead, StDrain}) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ifm_bram_ctrl.sv
// Directed self-checking bench for ifm_bram_ctrl with a small behavioural BRAM.
module tb_ifm_bram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifm_bram_ctrl_if #(.LEN_W(32)) bus ();

  ifm_bram_ctrl #(
    .DEPTH(100352),
    .LEN_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // BRAM model: 128-bit write at word address, 32-bit read at byte address, 1-cycle latency.
  logic [31:0] mem [64];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
      mem_init = 1'b1;
    end
    if (bus.bram_wr_en) begin
      for (int j = 0; j < 4; j++) mem[(int'(bus.bram_wr_addr) + j) % 64] = bus.bram_data_in[32*j +: 32];
    end
    bus.bram_data_out <= mem[int'(bus.bram_rd_addr[7:2])];
  end

  // Event logs, sampled on the falling edge.
  logic [31:0]  wr_addr_log [$];
  logic [127:0] wr_data_log [$];
  logic [31:0]  ifm_log [$];
  logic [31:0]  rda_log [$];
  int           done_cnt = 0;
  int           cyc = 0;
  int           last_ifm_cyc = 0;
  int           done_cyc = 0;
  logic [31:0]  prev_rd_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (bus.bram_wr_en) begin
      wr_addr_log.push_back(bus.bram_wr_addr);
      wr_data_log.push_back(bus.bram_data_in);
    end
    if (bus.ifm_valid) begin
      ifm_log.push_back(bus.ifm_data);
      rda_log.push_back(prev_rd_addr);
      last_ifm_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_rd_addr = bus.bram_rd_addr;
  end

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    ifm_log.delete();
    rda_log.delete();
    done_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] beat(input logic [31:0] base, input int k);
    logic [31:0] w0;
    w0 = base + 32'(4 * k);
    return {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
  endfunction

  task automatic start_job(input logic [31:0] ll, input logic [31:0] rl);
    bus.load_len = ll;
    bus.read_len = rl;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Offers beats with in_valid following vpat, advancing on each handshake.
  task automatic feed(input int nbeats, input logic [7:0] vpat, input logic [31:0] base);
    int   k = 0;
    int   c = 0;
    logic hs;
    while (k < nbeats && c < 200) begin
      bus.in_valid = vpat[c % 8];
      bus.in_data  = beat(base, k);
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      tick();
      if (hs) k++;
      c++;
    end
    bus.in_valid = 1'b0;
    total++;
    if (k != nbeats) begin
      bad++;
      $display("FAIL feed_beats: accepted=%0d required=%0d", k, nbeats);
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL %s_done_timeout: done_cnt=%0d required=%0d", name, done_cnt, target);
    end
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({bus.in_ready, bus.bram_wr_en, bus.ifm_valid, bus.busy, bus.done} !== 5'b0) begin
      bad++;
      $display("FAIL %s_flags: got=%b required=00000", name,
               {bus.in_ready, bus.bram_wr_en, bus.ifm_valid, bus.busy, bus.done});
    end
    total++;
    if (bus.bram_wr_addr !== 32'h0 || bus.bram_rd_addr !== 32'h0 || bus.ifm_data !== 32'h0) begin
      bad++;
      $display("FAIL %s_addrs: wr_addr=%h rd_addr=%h ifm_data=%h required=0", name,
               bus.bram_wr_addr, bus.bram_rd_addr, bus.ifm_data);
    end
    total++;
    if (bus.bram_data_in !== 128'h0) begin
      bad++;
      $display("FAIL %s_data_in: got=%h required=0", name, bus.bram_data_in);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_busy: got=%b required=0", bus.busy);
    end
  endtask

  task automatic test_basic();
    logic [31:0] base = 32'h1000_0000;
    clear_logs();
    start_job(8, 8);
    feed(2, 8'hFF, base);
    wait_done(1, "basic");
    total++;
    if (wr_addr_log.size() != 2) begin
      bad++;
      $display("FAIL basic_wr_count: got=%0d required=2", wr_addr_log.size());
    end
    for (int i = 0; i < wr_addr_log.size() && i < 2; i++) begin
      total++;
      if (wr_addr_log[i] !== 32'(4 * i) || wr_data_log[i] !== beat(base, i)) begin
        bad++;
        $display("FAIL basic_wr_%0d: addr=%h data=%h required addr=%h data=%h", i,
                 wr_addr_log[i], wr_data_log[i], 32'(4 * i), beat(base, i));
      end
    end
    total++;
    if (ifm_log.size() != 8) begin
      bad++;
      $display("FAIL basic_ifm_count: got=%0d required=8", ifm_log.size());
    end
    for (int i = 0; i < ifm_log.size() && i < 8; i++) begin
      total++;
      if (ifm_log[i] !== base + 32'(i) || rda_log[i] !== 32'(4 * i)) begin
        bad++;
        $display("FAIL basic_ifm_%0d: data=%h rd_addr=%h required data=%h rd_addr=%h", i,
                 ifm_log[i], rda_log[i], base + 32'(i), 32'(4 * i));
      end
    end
    total++;
    if (done_cnt != 1 || done_cyc != last_ifm_cyc + 1) begin
      bad++;
      $display("FAIL basic_done_timing: done_cnt=%0d done_cyc=%0d required 1 at cyc %0d",
               done_cnt, done_cyc, last_ifm_cyc + 1);
    end
  endtask

  task automatic test_valid_toggle();
    logic [31:0] base = 32'h2000_0000;
    clear_logs();
    bus.in_valid = 1'b1;
    bus.in_data  = beat(base, 0);
    start_job(4, 1);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.bram_wr_en !== 1'b0) begin
        bad++;
        $display("FAIL toggle_wait_%0d: in_ready=%b wr_en=%b required 1,0", c,
                 bus.in_ready, bus.bram_wr_en);
      end
      tick();
    end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.bram_wr_en !== 1'b1 || bus.bram_wr_addr !== 32'h0 || bus.bram_data_in !== beat(base, 0)) begin
      bad++;
      $display("FAIL toggle_write: wr_en=%b addr=%h data=%h required 1,0,%h", bus.bram_wr_en,
               bus.bram_wr_addr, bus.bram_data_in, beat(base, 0));
    end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL toggle_ready_after: got=%b required=0", bus.in_ready);
    end
    wait_done(1, "toggle");
    total++;
    if (wr_addr_log.size() != 1) begin
      bad++;
      $display("FAIL toggle_wr_count: got=%0d required=1", wr_addr_log.size());
    end
    total++;
    if (ifm_log.size() != 1 || ifm_log[0] !== base) begin
      bad++;
      $display("FAIL toggle_readback: count=%0d required 1 word %h", ifm_log.size(), base);
    end
  endtask

  task automatic test_zero_load();
    clear_logs();
    start_job(0, 2);
    total++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_load_flush: busy=%b in_ready=%b required 1,0", bus.busy, bus.in_ready);
    end
    wait_done(1, "zero_load");
    total++;
    if (wr_addr_log.size() != 0) begin
      bad++;
      $display("FAIL zero_load_writes: got=%0d required=0", wr_addr_log.size());
    end
    total++;
    if (ifm_log.size() != 2 || ifm_log[0] !== 32'h2000_0000 || ifm_log[1] !== 32'h2000_0001) begin
      bad++;
      $display("FAIL zero_load_ifm: count=%0d required 2 words 20000000,20000001", ifm_log.size());
    end
  endtask

  task automatic test_zero_read();
    clear_logs();
    start_job(4, 0);
    feed(1, 8'hFF, 32'h3000_0000);
    wait_done(1, "zero_read");
    total++;
    if (ifm_log.size() != 0 || done_cnt != 1 || wr_addr_log.size() != 1) begin
      bad++;
      $display("FAIL zero_read: ifm=%0d done=%0d writes=%0d required 0,1,1", ifm_log.size(),
               done_cnt, wr_addr_log.size());
    end
  endtask

  task automatic test_restart_ignored();
    int n = 0;
    clear_logs();
    start_job(4, 8);
    bus.load_len = 100;
    bus.read_len = 3;
    feed(1, 8'hFF, 32'h4000_0000);
    while (ifm_log.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(1, "restart");
    repeat (3) tick();
    total++;
    if (done_cnt != 1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_done: done_cnt=%0d busy=%b required 1,0", done_cnt, bus.busy);
    end
    total++;
    if (ifm_log.size() != 8) begin
      bad++;
      $display("FAIL restart_ifm_count: got=%0d required=8", ifm_log.size());
    end else begin
      total++;
      if (ifm_log[0] !== 32'h4000_0000 || ifm_log[3] !== 32'h4000_0003 || ifm_log[4] !== 32'h1000_0004) begin
        bad++;
        $display("FAIL restart_ifm_data: got=%h,%h,%h required 40000000,40000003,10000004",
                 ifm_log[0], ifm_log[3], ifm_log[4]);
      end
    end
    bus.load_len = 0;
    bus.read_len = 0;
  endtask

  task automatic test_rst_mid_load();
    logic [31:0] base = 32'h6000_0000;
    clear_logs();
    start_job(8, 8);
    bus.in_valid = 1'b1;
    bus.in_data  = beat(32'h5000_0000, 0);
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    repeat (2) tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    clear_logs();
    repeat (5) tick();
    total++;
    if (wr_addr_log.size() != 0 || ifm_log.size() != 0 || done_cnt != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_quiet: writes=%0d ifm=%0d done=%0d busy=%b required 0,0,0,0",
               wr_addr_log.size(), ifm_log.size(), done_cnt, bus.busy);
    end
    start_job(4, 4);
    feed(1, 8'hFF, base);
    wait_done(1, "rst_fresh");
    total++;
    if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 32'h0) begin
      bad++;
      $display("FAIL rst_fresh_addr: writes=%0d required one write at address 0", wr_addr_log.size());
    end
    for (int i = 0; i < ifm_log.size() && i < 4; i++) begin
      total++;
      if (ifm_log[i] !== base + 32'(i)) begin
        bad++;
        $display("FAIL rst_fresh_ifm_%0d: got=%h required=%h", i, ifm_log[i], base + 32'(i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.load_len = '0;
    bus.read_len = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_basic();
    test_valid_toggle();
    test_zero_load();
    test_zero_read();
    test_restart_ignored();
    test_rst_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
